load_store_unit: RTL and testbench

- Sits between the execute stage and the word-wide data memory.
- Converts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses, and sign- or zero-extends load data.
- Memory has full-word write only, so sub-word stores are done as a two-cycle read-modify-write.
- Flags misaligned or illegal accesses instead of touching memory.

---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 56 +++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 encodings (F3_*)
//   - lsu_state_t : control FSM states
//   - access_legal(): legality of a (we, funct3, addr[1:0]) combination
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MERGE_WR = 2'd2,
        RESP     = 2'd3
    } lsu_state_t;

    // Unsigned loads have no store counterpart, and every width must be
    // naturally aligned. Anything not listed is illegal.
    function automatic logic access_legal(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
        case (funct3)
            F3_B:    access_legal = 1'b1;
            F3_H:    access_legal = !addr_lo[0];
            F3_W:    access_legal = (addr_lo == 2'b00);
            F3_BU:   access_legal = !we;
            F3_HU:   access_legal = !we && !addr_lo[0];
            default: access_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for 32-bit words.
//   funct3_i    : load/store size and signedness
//   addr_lo_i   : byte offset inside the word (addr[1:0])
//   rdata_i     : word read from memory
//   wdata_i     : store data (rs2)
//   load_data_o : selected lane, sign- or zero-extended to 32 bits
//   merged_o    : rdata_i with the addressed byte/halfword replaced by wdata_i
// Outputs for illegal funct3/offset combinations are don't-care to the caller.
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_i[8*addr_lo_i +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data_o = rdata_i;
            F3_BU:   load_data_o = {24'd0, byte_sel};
            F3_HU:   load_data_o = {16'd0, half_sel};
            default: load_data_o = '0;
        endcase
    end

    always_comb begin
        merged_o = rdata_i;
        case (funct3_i)
            F3_B: merged_o[8*addr_lo_i +: 8] = wdata_i[7:0];
            F3_H: begin
                if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
                else              merged_o[15:0]  = wdata_i[15:0];
            end
            F3_W:    merged_o = wdata_i;
            default: merged_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Bridges byte-addressed RV32I loads/stores to a word-wide memory with
// full-word writes only. Sub-word stores are a read-modify-write over two
// cycles; illegal or misaligned accesses never touch memory and complete
// with resp_err.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : request handshake (accept on valid && ready)
//   req_we, req_funct3       : store/load and RV32I funct3
//   req_addr, req_wdata      : byte address and store data
//   resp_valid               : one-cycle completion pulse
//   resp_rdata, resp_err     : load result / error flag, held until next resp
//   mem_addr, mem_wen        : word index and write enable to memory
//   mem_wdata                : full word to write
//   mem_rdata                : combinational read data of mem_addr
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [DATA_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_wen,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_t state_q, state_d;

    // Only the bits that reach memory plus the byte offset are kept; the
    // upper address bits are ignored by design.
    logic [ADDRESS_WIDTH+1:0] addr_q;
    logic [2:0]               funct3_q;
    logic                     we_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    merged_q;
    logic [DATA_WIDTH-1:0]    resp_rdata_q;
    logic                     resp_err_q;

    logic                     accept;
    logic                     legal;
    logic                     is_word_store;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merged;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^req_addr[DATA_WIDTH-1:ADDRESS_WIDTH+2];

    assign req_ready     = (state_q == IDLE) && !rst;
    assign accept        = req_valid && req_ready;
    assign legal         = access_legal(we_q, funct3_q, addr_q[1:0]);
    assign is_word_store = we_q && (funct3_q == F3_W);

    assign mem_addr   = addr_q[ADDRESS_WIDTH+1:2];
    assign mem_wdata  = (state_q == MERGE_WR) ? merged_q : wdata_q;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    lsu_lane_align u_lane_align (
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .rdata_i     (mem_rdata),
        .wdata_i     (wdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    // Next state and write enable. The write strobe is gated by rst so a
    // reset arriving mid-RMW can never corrupt the target word.
    always_comb begin
        state_d = state_q;
        mem_wen = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACCESS;
            end
            ACCESS: begin
                if (legal && we_q && !is_word_store) begin
                    state_d = MERGE_WR;
                end else begin
                    state_d = RESP;
                    mem_wen = legal && is_word_store;
                end
            end
            MERGE_WR: begin
                state_d = RESP;
                mem_wen = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) mem_wen = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            merged_q     <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                addr_q   <= req_addr[ADDRESS_WIDTH+1:0];
                funct3_q <= req_funct3;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
            end

            // Response fields are settled in ACCESS and then held through
            // RESP and beyond, until the next request reaches ACCESS.
            if (state_q == ACCESS) begin
                resp_err_q   <= !legal;
                resp_rdata_q <= (legal && !we_q) ? load_data : '0;
                if (legal && we_q && !is_word_store) merged_q <= merged;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench: directed cases followed by random loads/stores, each
// checked against an arithmetic reference model of memory and of the
// unit's response timing.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int AW        = 20;
    localparam int DW        = 32;
    localparam int MEM_WORDS = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [DW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [31:0] tb_mem  [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int checks   = 0;
    int failures = 0;
    int wen_total = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Word memory seen by the DUT: combinational read, write on the edge.
    assign mem_rdata = tb_mem[mem_addr[11:0]];
    always @(posedge clk) if (mem_wen) tb_mem[mem_addr[11:0]] <= mem_wdata;
    always @(negedge clk) if (mem_wen) wen_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, observe it cycle by cycle, and compare against the
    // reference model. Cycle k means k cycles after the accepting edge.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata);
        int          size;
        bit          legal;
        logic [11:0] idx;
        logic [31:0] word, sh, v, mask, exp_rdata, exp_word;
        int          exp_resp, exp_wen_cnt, exp_wen_cyc;
        int          resp_cyc, wen_cnt, wen_cyc;
        logic [31:0] wen_addr, wen_data;
        logic        got_err, post_valid, post_ready;

        // ---- reference model ----
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (addr % size != 0) legal = 1'b0;
        idx       = addr[13:2];
        word      = ref_mem[idx];
        exp_word  = word;
        exp_rdata = 32'd0;
        exp_resp  = 2;
        exp_wen_cnt = 0;
        exp_wen_cyc = -1;
        if (legal && !we) begin
            sh = word >> (8 * addr[1:0]);
            if (size == 1) begin
                v = sh & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end else if (size == 2) begin
                v = sh & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end else begin
                v = word;
            end
            exp_rdata = v;
        end else if (legal && we) begin
            mask = (size == 4) ? 32'hFFFF_FFFF
                 : (((size == 2) ? 32'hFFFF : 32'hFF) << (8 * addr[1:0]));
            exp_word    = (word & ~mask) | ((wdata << (8 * addr[1:0])) & mask);
            exp_wen_cnt = 1;
            exp_wen_cyc = (size == 4) ? 1 : 2;
            exp_resp    = (size == 4) ? 2 : 3;
            ref_mem[idx] = exp_word;
        end

        // ---- drive and observe ----
        @(negedge clk);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        resp_cyc = -1; wen_cnt = 0; wen_cyc = -1;
        wen_addr = '0; wen_data = '0;
        got_rdata = '0; got_err = 1'b0;
        post_valid = 1'b1; post_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (resp_cyc >= 0 && k == resp_cyc + 1) begin
                post_valid = resp_valid;
                post_ready = req_ready;
                break;
            end
            if (mem_wen) begin
                wen_cnt++;
                wen_cyc  = k;
                wen_addr = {12'd0, mem_addr};
                wen_data = mem_wdata;
            end
            if (resp_valid && resp_cyc < 0) begin
                resp_cyc  = k;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end

        check({tag, "_latency"}, 32'(resp_cyc), 32'(exp_resp));
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, !legal});
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_wen_count"}, 32'(wen_cnt), 32'(exp_wen_cnt));
        if (exp_wen_cnt == 1) begin
            check({tag, "_wen_cycle"}, 32'(wen_cyc), 32'(exp_wen_cyc));
            check({tag, "_wen_addr"}, wen_addr, {12'd0, addr[21:2]});
            check({tag, "_wen_data"}, wen_data, exp_word);
        end
        check({tag, "_pulse_end"}, {31'd0, post_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, post_ready}, 32'd1);
        check({tag, "_mem_word"}, tb_mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          wen_before;
        int          mism;

        for (int i = 0; i < MEM_WORDS; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[12'h10]  = 32'h8899AABB;
        ref_mem[12'h10] = 32'h8899AABB;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;

        // ---- reset behaviour ----
        @(negedge clk);
        @(negedge clk);
        check("rst_ready_low", {31'd0, req_ready}, 32'd0);
        check("rst_wen_low", {31'd0, mem_wen}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_err", {31'd0, resp_err}, 32'd0);
        check("reset_rdata", resp_rdata, 32'd0);

        // ---- directed cases ----
        do_req("lb_41",  1'b0, 3'b000, 32'h41, 32'h0, rd);
        check("lb_41_const", rd, 32'hFFFFFFAA);
        do_req("lbu_43", 1'b0, 3'b100, 32'h43, 32'h0, rd);
        check("lbu_43_const", rd, 32'h00000088);
        do_req("lhu_42", 1'b0, 3'b101, 32'h42, 32'h0, rd);
        check("lhu_42_const", rd, 32'h00008899);
        do_req("lh_40",  1'b0, 3'b001, 32'h40, 32'h0, rd);
        check("lh_40_const", rd, 32'hFFFFAABB);
        do_req("sb_42",  1'b1, 3'b000, 32'h42, 32'h12345611, rd);
        do_req("lw_40",  1'b0, 3'b010, 32'h40, 32'h0, rd);
        check("lw_40_const", rd, 32'h8811AABB);
        do_req("sw_44",  1'b1, 3'b010, 32'h44, 32'hDEADBEEF, rd);
        check("sw_44_const", tb_mem[12'h11], 32'hDEADBEEF);
        do_req("lh_41_err",  1'b0, 3'b001, 32'h41, 32'h0, rd);
        do_req("sw_46_err",  1'b1, 3'b010, 32'h46, 32'hCAFEF00D, rd);
        do_req("ld_f3_err",  1'b0, 3'b011, 32'h40, 32'h0, rd);
        do_req("sh_42",      1'b1, 3'b001, 32'h42, 32'hFFFF5A5A, rd);

        // ---- reset in the middle of an SH read-modify-write ----
        wen_before = wen_total;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h40; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
        check("rmw_rst_valid", {31'd0, resp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        check("rmw_rst_no_wen", 32'(wen_total - wen_before), 32'd0);
        check("rmw_rst_mem", tb_mem[12'h10], ref_mem[12'h10]);
        check("rmw_rst_idle_valid", {31'd0, resp_valid}, 32'd0);

        // ---- random traffic ----
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(0, 16383);
            a = a | ($urandom & 32'hFFC0_0000);
            do_req("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   a, $urandom, rd);
        end

        mism = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        check("mem_final", 32'(mism), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
